// File: rtl/axi4_lite_slave_write_responder.sv
// AXI4-Lite write-channel slave: per-channel programmable ready delay,
// strobed merge into a small word-addressed register file, OKAY/SLVERR response.
module axi4_lite_slave_write_responder #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DELAY_WIDTH   = 4,
    parameter int unsigned NUM_REGS      = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ADDRESS_WIDTH-1:0]    awaddr,
    input  logic [2:0]                  awprot,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [DATA_WIDTH/8-1:0]     wstrb,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [1:0]                  bresp,
    output logic                        bvalid,
    input  logic                        bready,
    input  logic [DELAY_WIDTH-1:0]      delay_for_ready,
    input  logic [$clog2(NUM_REGS)-1:0] rd_index,
    output logic [DATA_WIDTH-1:0]       rd_data
);

    localparam int unsigned IDXW  = $clog2(NUM_REGS);
    localparam int unsigned LANES = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]               aw_state;
    logic [1:0]               w_state;
    logic [DELAY_WIDTH-1:0]   aw_cnt;
    logic [DELAY_WIDTH-1:0]   w_cnt;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic [2:0]               awprot_unused_q;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [LANES-1:0]         w_strb_q;
    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

    logic                     aw_fire;
    logic                     w_fire;
    logic                     b_done;
    logic                     aw_have;
    logic                     w_have;
    logic                     do_write;
    logic [ADDRESS_WIDTH-1:0] addr_eff;
    logic [DATA_WIDTH-1:0]    data_eff;
    logic [LANES-1:0]         strb_eff;
    logic [IDXW-1:0]          wr_index;
    logic                     addr_ok;

    assign awready = (aw_state == ST_WAIT) && (aw_cnt == '0);
    assign wready  = (w_state == ST_WAIT) && (w_cnt == '0);
    assign aw_fire = awready && awvalid;
    assign w_fire  = wready && wvalid;
    assign b_done  = bvalid && bready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_state        <= ST_IDLE;
            aw_cnt          <= '0;
            aw_addr_q       <= '0;
            awprot_unused_q <= '0;
        end else begin
            case (aw_state)
                ST_IDLE: if (awvalid) begin
                    aw_cnt   <= delay_for_ready;
                    aw_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (aw_cnt != '0) begin
                        aw_cnt <= aw_cnt - DELAY_WIDTH'(1);
                    end else if (awvalid) begin
                        aw_addr_q       <= awaddr;
                        awprot_unused_q <= awprot;
                        aw_state        <= ST_FULL;
                    end else begin
                        aw_state <= ST_IDLE;
                    end
                end
                ST_FULL: if (b_done) aw_state <= ST_IDLE;
                default: aw_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state  <= ST_IDLE;
            w_cnt    <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            case (w_state)
                ST_IDLE: if (wvalid) begin
                    w_cnt   <= delay_for_ready;
                    w_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_cnt != '0) begin
                        w_cnt <= w_cnt - DELAY_WIDTH'(1);
                    end else if (wvalid) begin
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                        w_state  <= ST_FULL;
                    end else begin
                        w_state <= ST_IDLE;
                    end
                end
                ST_FULL: if (b_done) w_state <= ST_IDLE;
                default: w_state <= ST_IDLE;
            endcase
        end
    end

    // A handshake completing this cycle bypasses its buffer, so the write and
    // bvalid land on the same edge that fills the later of the two buffers.
    always_comb begin
        aw_have  = (aw_state == ST_FULL) || aw_fire;
        w_have   = (w_state == ST_FULL) || w_fire;
        addr_eff = aw_fire ? awaddr : aw_addr_q;
        data_eff = w_fire ? wdata : w_data_q;
        strb_eff = w_fire ? wstrb : w_strb_q;
        do_write = aw_have && w_have && !bvalid;
        wr_index = addr_eff[IDXW+1:2];
        addr_ok  = (addr_eff[1:0] == 2'b00) && ((addr_eff >> (IDXW + 2)) == '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (do_write) begin
            bvalid <= 1'b1;
            bresp  <= addr_ok ? RESP_OKAY : RESP_SLVERR;
            if (addr_ok) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (strb_eff[i]) begin
                        regs[wr_index][8*i +: 8] <= data_eff[8*i +: 8];
                    end
                end
            end
        end else if (b_done) begin
            bvalid <= 1'b0;
        end
    end

    assign rd_data = regs[rd_index];

endmodule

// File: tb/tb_axi4_lite_slave_write_responder.sv
// Directed bench: stimulus pushes expected BRESP into a queue, a monitor pops
// it on every B handshake; ready timing and register contents checked inline.
module tb_axi4_lite_slave_write_responder;

    logic        aclk;
    logic        aresetn;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  delay_for_ready;
    logic [3:0]  rd_index;
    logic [31:0] rd_data;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  sb [$];

    axi4_lite_slave_write_responder #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .DELAY_WIDTH  (4),
        .NUM_REGS     (16)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .awaddr         (awaddr),
        .awprot         (awprot),
        .awvalid        (awvalid),
        .awready        (awready),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wvalid         (wvalid),
        .wready         (wready),
        .bresp          (bresp),
        .bvalid         (bvalid),
        .bready         (bready),
        .delay_for_ready(delay_for_ready),
        .rd_index       (rd_index),
        .rd_data        (rd_data)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge aclk) begin
        if (aresetn && bvalid && bready) begin
            if (sb.size() == 0) begin
                chk("unexpected B response", 32'(bresp), 32'hFFFF_FFFF);
            end else begin
                chk("scoreboard bresp", 32'(bresp), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic smp();
        @(negedge aclk);
    endtask

    task automatic ports(input logic ea, input logic ew, input logic eb, input string tag);
        chk({tag, " awready"}, 32'(awready), 32'(ea));
        chk({tag, " wready"}, 32'(wready), 32'(ew));
        chk({tag, " bvalid"}, 32'(bvalid), 32'(eb));
    endtask

    task automatic reg_is(input int idx, input logic [31:0] want);
        rd_index = 4'(idx);
        #1;
        chk($sformatf("reg%0d", idx), rd_data, want);
    endtask

    // AW and W presented together in cycle 0; checks ready/bvalid cycle by cycle.
    task automatic timed_both(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int d,
                              input logic [1:0] resp, input string tag);
        for (int k = 0; k <= d + 3; k++) begin
            tick();
            if (k == 0) begin
                awaddr = addr; awvalid = 1'b1;
                wdata = data; wstrb = strb; wvalid = 1'b1;
                delay_for_ready = 4'(d);
                sb.push_back(resp);
            end
            if (k == d + 2) begin
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end
            smp();
            ports(k == d + 1, k == d + 1, k == d + 2, $sformatf("%s c%0d", tag, k));
            if (k == d + 2) chk({tag, " bresp"}, 32'(bresp), 32'(resp));
        end
    endtask

    // Handshake-driven transfer with a bounded wait for the response.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int d, input logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit b_seen  = 0;
        int n       = 0;
        tick();
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        delay_for_ready = 4'(d);
        sb.push_back(resp);
        while (!b_seen && n < 40) begin
            smp();
            if (awready) aw_done = 1;
            if (wready) w_done = 1;
            if (bvalid) b_seen = 1;
            tick();
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            n++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk($sformatf("xfer %h response seen", addr), 32'(b_seen), 32'd1);
    endtask

    initial begin
        aresetn = 1'b0; awaddr = '0; awprot = 3'b010; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        delay_for_ready = '0; rd_index = '0;

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        ports(1'b0, 1'b0, 1'b0, "reset");
        chk("reset bresp", 32'(bresp), 32'd0);
        aresetn = 1'b1;
        for (int i = 0; i < 16; i++) reg_is(i, 32'h0);

        // D=0, both channels in cycle 0
        bready = 1'b1;
        timed_both(32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, "d0");
        reg_is(2, 32'hDEAD_BEEF);

        // D=3, W five cycles before AW; delay changes after latch must be ignored
        for (int k = 0; k <= 11; k++) begin
            tick();
            if (k == 0) begin
                wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1;
                delay_for_ready = 4'd3;
                sb.push_back(2'b00);
            end
            if (k == 1) delay_for_ready = 4'd9;
            if (k == 5) begin
                awaddr = 32'h0000_0004; awvalid = 1'b1;
                delay_for_ready = 4'd3;
            end
            if (k == 6) delay_for_ready = 4'd0;
            if (k == 10) begin
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end
            smp();
            ports(k == 9, k == 4, k == 10, $sformatf("stagger c%0d", k));
        end
        reg_is(1, 32'h1122_3344);

        // partial strobes and empty strobe
        xfer(32'h0000_0004, 32'hAABB_CCDD, 4'b0101, 0, 2'b00);
        reg_is(1, 32'h11BB_33DD);
        xfer(32'h0000_0008, 32'hFFFF_FFFF, 4'b0000, 2, 2'b00);
        reg_is(2, 32'hDEAD_BEEF);

        // decode errors leave every register untouched
        xfer(32'h0000_0040, 32'h1234_5678, 4'hF, 1, 2'b10);
        xfer(32'h0000_0006, 32'h1234_5678, 4'hF, 0, 2'b10);
        xfer(32'h8000_0004, 32'h1234_5678, 4'hF, 0, 2'b10);
        for (int i = 0; i < 16; i++)
            reg_is(i, (i == 1) ? 32'h11BB_33DD : (i == 2) ? 32'hDEAD_BEEF : 32'h0);

        // maximum delay
        timed_both(32'h0000_003C, 32'h0F0F_0F0F, 4'hF, 15, 2'b00, "d15");
        reg_is(15, 32'h0F0F_0F0F);

        // bready held low: response stable, no new acceptance until B completes
        bready = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            tick();
            if (k == 0) begin
                awaddr = 32'h0000_000D; awvalid = 1'b1;
                wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
                delay_for_ready = 4'd0;
                sb.push_back(2'b10);
            end
            if (k == 2) begin
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end
            if (k == 3) begin
                awaddr = 32'h0000_000C; awvalid = 1'b1;
                wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
                delay_for_ready = 4'd2;
                sb.push_back(2'b00);
            end
            if (k == 12) bready = 1'b1;
            if (k == 17) begin
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end
            smp();
            ports(k == 1 || k == 16, k == 1 || k == 16,
                  (k >= 2 && k <= 12) || k == 17, $sformatf("bstall c%0d", k));
            if (k >= 2 && k <= 12) chk($sformatf("bstall bresp c%0d", k), 32'(bresp), 32'd2);
            if (k == 5) reg_is(3, 32'h0);
        end
        reg_is(3, 32'h0BAD_F00D);

        // reset while AW is buffered and W is in its ready cycle
        tick();
        awaddr = 32'h0000_0014; awvalid = 1'b1; delay_for_ready = 4'd0;
        smp();
        tick();
        wdata = 32'h9999_9999; wstrb = 4'hF; wvalid = 1'b1; delay_for_ready = 4'd1;
        smp();
        chk("rst awready c1", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
        smp();
        tick();
        smp();
        chk("rst wready c3", 32'(wready), 32'd1);
        #1;
        aresetn = 1'b0;
        #1;
        ports(1'b0, 1'b0, 1'b0, "async reset");
        chk("async reset bresp", 32'(bresp), 32'd0);
        wvalid = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        reg_is(5, 32'h0);
        reg_is(2, 32'h0);
        xfer(32'h0000_0014, 32'hCAFE_0001, 4'hF, 0, 2'b00);
        reg_is(5, 32'hCAFE_0001);

        tick();
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
